row_formatter: RTL

Streaming formatter that turns a parallel word of fixed-width fields into one ASCII text row in the exact format the bench's row parser consumes. Each field is written as binary characters, MSB first, with a single space between fields and a newline after the last field. It sits at the DUT or bench boundary, feeding a byte sink such as a file-writer shim or UART, so hardware-generated vectors can be replayed by the text-driven testbench flow.

---
 rtl/row_formatter.sv | 116 +++++++++++
 1 files changed

// File: rtl/row_formatter.sv
// Streams a word of NUM_FIELDS x FIELD_W bit fields as one ASCII text row:
// binary digits MSB first, ' ' between fields, '\n' after the last field.
module row_formatter #(
    parameter int NUM_FIELDS = 3,
    parameter int FIELD_W    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_FIELDS*FIELD_W-1:0]    in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [7:0]                       out_byte,
    output logic                             out_last,
    output logic                             busy,
    output logic [15:0]                      row_count
);

    localparam int TOTAL_W = NUM_FIELDS * FIELD_W;
    localparam int FIDX_W  = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int BIDX_W  = $clog2(FIELD_W + 1);

    localparam logic [FIDX_W-1:0] LAST_FIELD = FIDX_W'(NUM_FIELDS - 1);
    localparam logic [BIDX_W-1:0] SEP_SLOT   = BIDX_W'(FIELD_W);

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_1  = 8'h31;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_NL = 8'h0A;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t              state_q, state_d;
    logic [TOTAL_W-1:0]  data_q, data_d;
    logic [FIDX_W-1:0]   field_q, field_d;
    logic [BIDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [7:0]          byte_d;
    logic                last_d;
    logic [15:0]         count_d;
    logic                fire, done, accept;

    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q == EMIT);
    assign fire      = out_valid && out_ready;
    assign done      = fire && out_last;
    assign in_ready  = !rst && ((state_q == IDLE) || done);
    assign accept    = in_valid && in_ready;

    // data_q is a shift register: its MSB is always the next bit character
    // still to be emitted, so the current character is never re-indexed.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_d   = state_q;
        data_d    = data_q;
        field_d   = field_q;
        bit_idx_d = bit_idx_q;
        byte_d    = out_byte;
        last_d    = out_last;
        count_d   = row_count;

        if (done) begin
            count_d = row_count + 16'd1;
            state_d = IDLE;
            byte_d  = 8'h00;
            last_d  = 1'b0;
        end else if (fire) begin
            if (bit_idx_q == SEP_SLOT) begin
                field_d   = field_q + FIDX_W'(1);
                bit_idx_d = '0;
            end else begin
                bit_idx_d = bit_idx_q + BIDX_W'(1);
            end

            if (bit_idx_d == SEP_SLOT) begin
                last_d = (field_d == LAST_FIELD);
                byte_d = last_d ? CH_NL : CH_SP;
            end else begin
                byte_d = data_q[TOTAL_W-1] ? CH_1 : CH_0;
                data_d = data_q << 1;
            end
        end

        // Acceptance overrides completion so back-to-back rows have no bubble.
        if (accept) begin
            state_d   = EMIT;
            data_d    = in_data << 1;
            field_d   = '0;
            bit_idx_d = '0;
            byte_d    = in_data[TOTAL_W-1] ? CH_1 : CH_0;
            last_d    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            field_q   <= '0;
            bit_idx_q <= '0;
            out_byte  <= 8'h00;
            out_last  <= 1'b0;
            row_count <= 16'h0000;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            field_q   <= field_d;
            bit_idx_q <= bit_idx_d;
            out_byte  <= byte_d;
            out_last  <= last_d;
            row_count <= count_d;
        end
    end

endmodule
